psk_frame_sync: RTL and testbench
=================================

Name: psk_frame_sync

Overview:
- Downstream of the PSK demodulator; consumes the decimated, DC-removed baseband stream (ac_data, qualified by ds_clk).
- Performs hysteresis slicing, zero-crossing symbol timing recovery, and sync-word hunting with polarity-ambiguity resolution.
- Assembles payload bytes for the frame consumer.
- Single clock domain at the system clock; din_valid carries the decimated sample rate.

Parameters:
- DW, 12, input sample width (signed).
- SPS, 16, samples per symbol at din_valid rate (power of two, ≥4).
- HYST, 64, slicer hysteresis magnitude in LSBs.
- SYNC_W, 16, sync word length in bits.
- SYNC_WORD, 16'hD391, sync pattern, MSB first.
- MAX_ERR, 1, maximum Hamming distance accepted as a sync match.
- FRAME_BYTES, 8, payload bytes per frame after the sync word.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  DW  signed baseband sample.
- din_valid  in  1  sample strobe, one clk wide.
- bit_out  out  1  sliced bit at the symbol centre.
- bit_valid  out  1  one-cycle strobe for bit_out.
- byte_out  out  8  payload byte, MSB = first received bit, polarity-corrected.
- byte_valid  out  1  one-cycle strobe for byte_out.
- frame_start  out  1  one-cycle pulse when the sync word is accepted.
- frame_end  out  1  one-cycle pulse coincident with byte_valid of the last payload byte.
- locked  out  1  high while in DATA state.
- inverted  out  1  polarity flag latched at sync acceptance.

Behaviour:
- Reset: all outputs 0. Internal state: slicer state s=0, phase ph=0, shift register all 0, FSM=HUNT, byte count 0, bit count 0.
- All internal state advances only on cycles with din_valid=1. Otherwise it holds, and all strobes are 0.
- Slicer:
  - s_next = 1 if din > +HYST.
  - s_next = 0 if din < -HYST.
  - Otherwise s holds.
  - Compare with din sign-extended to DW+1 bits; no overflow.
- Transition: s_next != s on a valid sample.
- Timing (ph counts 0..SPS-1 and wraps):
  - No transition: ph <= ph+1.
  - Transition with ph==0: ph <= 1.
  - Transition with 1 ≤ ph < SPS/2 (late): ph holds.
  - Transition with ph ≥ SPS/2 (early): ph <= ph+2 mod SPS.
  - Ideal lock puts transitions at ph==0.
- Decision:
  - On a valid sample with ph==SPS/2, register bit_out=s_next and pulse bit_valid on the next cycle (latency 1 clk from the din_valid edge).
  - A transition on that same sample applies to both the slicer and the phase update as specified above.
- Shift register: shifts bit_out in at each decision, newest bit in the LSB.
- FSM:
  - HUNT:
    - Every decision, compute d0 = popcount(shift ^ SYNC_WORD) and d1 = popcount(~shift ^ SYNC_WORD).
    - If d0 ≤ MAX_ERR: inverted<=0, go to DATA, pulse frame_start.
    - Else if d1 ≤ MAX_ERR: inverted<=1, go to DATA, pulse frame_start.
    - When both match (only possible with a degenerate parameter choice), d0 takes priority.
    - The comparison uses the shift contents including the current bit. frame_start fires 1 clk after bit_valid.
  - DATA:
    - Collect 8 bits MSB first, XORed with inverted.
    - On the 8th bit: byte_out valid, byte_valid pulses in the same cycle as frame_start would have (1 clk after bit_valid); bit count clears; byte count increments.
    - On byte FRAME_BYTES: frame_end pulses with byte_valid, FSM returns to HUNT, and the shift register clears to 0 so no false re-sync occurs on the tail.
- locked = (FSM==DATA). byte_out holds its last value between strobes.
- Reset mid-frame: immediate return to reset values; no frame_end is emitted.
- ph wrap: ph is a log2(SPS)-bit counter; natural modular wrap is required.

Decomposition:
- Package psk_rx_pkg:
  - FSM enum {HUNT, DATA}.
  - Function popcount over SYNC_W bits.
  - Localparam PH_W = $clog2(SPS).
- Sub-module psk_sync_corr:
  - Inputs: shift register and SYNC_WORD.
  - Outputs: registered-free match_pos and match_neg combinational flags.
- Slicer, timing, and FSM stay in the top module.

Test Plan:
- Square wave ±1000 with period 2·SPS samples (alternating bits), din_valid every 16 clk, initial phase offset 5 samples -> transitions converge to ph==0 within 12 symbols; bit_valid once per 16 samples; bits alternate.
- Preamble 0xAAAA, then 0xD391, then bytes 01 23 45 67 89 AB CD EF -> frame_start 1 clk after the 16th sync bit's bit_valid; 8 byte_valid with exactly those values; frame_end with 0xEF; locked returns to 0.
- Same frame with all samples negated -> match via d1; inverted=1; bytes still 01..EF.
- Sync word with one bit flipped (0xD393) -> accepted. Two bits flipped (0xD397) -> no frame_start; stays in HUNT.
- Noise of ±40 around a +500 level (|noise| < HYST) -> zero spurious transitions; bits constant 1.
- rst asserted mid-frame after 3 bytes -> all outputs 0 the same cycle; no frame_end; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/psk_rx_pkg.sv
// Shared types and helpers for the PSK frame synchroniser.
package psk_rx_pkg;

  localparam int SPS_DEF  = 16;
  localparam int PH_W     = $clog2(SPS_DEF);
  localparam int SYNC_LEN = 16;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } fsm_e;

  function automatic int popcount(input logic [SYNC_LEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/psk_sync_corr.sv
// Sync-word correlator: flags a match of the shift register against the sync
// pattern in either polarity, within the allowed Hamming distance.
module psk_sync_corr
  import psk_rx_pkg::*;
#(
  parameter int MAX_ERR = 1
) (
  input  logic [SYNC_LEN-1:0] shift,
  input  logic [SYNC_LEN-1:0] sync_word,
  output logic                match_pos,
  output logic                match_neg
);

  int d0;
  int d1;

  always_comb begin
    d0        = popcount(shift ^ sync_word);
    d1        = popcount(~shift ^ sync_word);
    match_pos = (d0 <= MAX_ERR);
    match_neg = (d1 <= MAX_ERR);
  end

endmodule

// File: rtl/psk_frame_sync.sv
// Hysteresis slicer, zero-crossing symbol timing, sync hunt and byte assembly.
//   state | meaning
//   HUNT  | correlating every decided bit against the sync word
//   DATA  | collecting FRAME_BYTES payload bytes, polarity-corrected
module psk_frame_sync
  import psk_rx_pkg::*;
#(
  parameter int                DW          = 12,
  parameter int                SPS         = 1 << PH_W,
  parameter int                HYST        = 64,
  parameter int                SYNC_W      = SYNC_LEN,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hD391,
  parameter int                MAX_ERR     = 1,
  parameter int                FRAME_BYTES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          bit_out,
  output logic          bit_valid,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic          frame_start,
  output logic          frame_end,
  output logic          locked,
  output logic          inverted
);

  localparam int PHW = $clog2(SPS);
  localparam int BCW = $clog2(FRAME_BYTES + 1);

  localparam logic signed [DW:0]  HYST_P = (DW+1)'(HYST);
  localparam logic signed [DW:0]  HYST_N = -HYST_P;
  localparam logic [PHW-1:0]      PH_ONE = PHW'(1);
  localparam logic [PHW-1:0]      PH_TWO = PHW'(2);
  localparam logic [PHW-1:0]      PH_MID = PHW'(SPS / 2);
  localparam logic [BCW-1:0]      LAST_BYTE = BCW'(FRAME_BYTES - 1);

  logic signed [DW:0] din_ext;
  logic               s_q;
  logic               s_nxt;
  logic               trans;
  logic [PHW-1:0]     ph_q;
  logic [PHW-1:0]     ph_nxt;
  logic               decide;
  logic [SYNC_W-1:0]  shift_q;
  logic               shift_clr;
  logic               match_pos;
  logic               match_neg;

  fsm_e               state_q;
  fsm_e               state_d;
  logic               inv_d;
  logic [2:0]         bit_cnt_q;
  logic [2:0]         bit_cnt_d;
  logic [BCW-1:0]     byte_cnt_q;
  logic [BCW-1:0]     byte_cnt_d;
  logic [6:0]         byte_sh_q;
  logic [6:0]         byte_sh_d;
  logic [7:0]         byte_out_d;
  logic               byte_valid_d;
  logic               frame_start_d;
  logic               frame_end_d;
  logic               rx_bit;

  assign din_ext = {din[DW-1], din};

  // Slicer decision and phase correction for the current sample.
  always_comb begin
    s_nxt = s_q;
    if (din_ext > HYST_P) begin
      s_nxt = 1'b1;
    end else if (din_ext < HYST_N) begin
      s_nxt = 1'b0;
    end
    trans = (s_nxt != s_q);

    if (!trans) begin
      ph_nxt = ph_q + PH_ONE;
    end else if (ph_q == '0) begin
      ph_nxt = PH_ONE;
    end else if (ph_q < PH_MID) begin
      ph_nxt = ph_q;
    end else begin
      ph_nxt = ph_q + PH_TWO;
    end

    decide = din_valid && (ph_q == PH_MID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= 1'b0;
      ph_q      <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      shift_q   <= '0;
    end else begin
      bit_valid <= decide;
      if (din_valid) begin
        s_q  <= s_nxt;
        ph_q <= ph_nxt;
      end
      if (decide) begin
        bit_out <= s_nxt;
        shift_q <= {shift_q[SYNC_W-2:0], s_nxt};
      end else if (shift_clr) begin
        shift_q <= '0;
      end
    end
  end

  psk_sync_corr #(
    .MAX_ERR (MAX_ERR)
  ) u_corr (
    .shift     (shift_q),
    .sync_word (SYNC_WORD),
    .match_pos (match_pos),
    .match_neg (match_neg)
  );

  // The FSM acts on the bit_valid cycle, so the shift register already holds
  // the newest bit when the correlator is consulted.
  always_comb begin
    state_d       = state_q;
    inv_d         = inverted;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_sh_d     = byte_sh_q;
    byte_out_d    = byte_out;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    shift_clr     = 1'b0;
    rx_bit        = bit_out ^ inverted;

    if (bit_valid) begin
      if (state_q == HUNT) begin
        if (match_pos || match_neg) begin
          inv_d         = !match_pos;
          state_d       = DATA;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          byte_cnt_d    = '0;
        end
      end else begin
        byte_sh_d = {byte_sh_q[5:0], rx_bit};
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d    = '0;
          byte_out_d   = {byte_sh_q, rx_bit};
          byte_valid_d = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            frame_end_d = 1'b1;
            state_d     = HUNT;
            shift_clr   = 1'b1;
            byte_cnt_d  = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      inverted    <= 1'b0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      byte_sh_q   <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inverted    <= inv_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      byte_sh_q   <= byte_sh_d;
      byte_out    <= byte_out_d;
      byte_valid  <= byte_valid_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
    end
  end

  assign locked = (state_q == DATA);

endmodule

// File: tb/tb_psk_frame_sync.sv
// Directed self-checking bench for psk_frame_sync.
module tb_psk_frame_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        din_valid;
  logic        bit_out;
  logic        bit_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        frame_start;
  logic        frame_end;
  logic        locked;
  logic        inverted;

  always #5 clk = ~clk;

  psk_frame_sync dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .locked      (locked),
    .inverted    (inverted)
  );

  int         checks = 0;
  int         errors = 0;
  int         gap;
  int         cyc;
  int         bits_seen;
  int         bv_cyc;
  int         fs_cnt;
  int         fs_lat;
  int         fs_bits;
  int         fe_cnt;
  logic       last_bit;
  logic       got_bit;
  logic       fs_inv;
  logic       fe_bv;
  logic       lock_seen;
  logic [7:0] fe_byte;
  logic [7:0] rx_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    cyc       = 0;
    bits_seen = 0;
    bv_cyc    = 0;
    fs_cnt    = 0;
    fs_lat    = -1;
    fs_bits   = -1;
    fe_cnt    = 0;
    last_bit  = 1'bx;
    got_bit   = 1'b0;
    fs_inv    = 1'bx;
    fe_bv     = 1'b0;
    lock_seen = 1'b0;
    fe_byte   = 8'h00;
    rx_bytes.delete();
  endtask

  task automatic observe();
    cyc++;
    if (bit_valid) begin
      bits_seen++;
      last_bit = bit_out;
      bv_cyc   = cyc;
      got_bit  = 1'b1;
    end
    if (frame_start) begin
      fs_cnt++;
      fs_lat  = cyc - bv_cyc;
      fs_bits = bits_seen;
      fs_inv  = inverted;
    end
    if (byte_valid) rx_bytes.push_back(byte_out);
    if (frame_end) begin
      fe_cnt++;
      fe_byte = byte_out;
      fe_bv   = byte_valid;
    end
    if (locked) lock_seen = 1'b1;
  endtask

  task automatic sample(input int v);
    din       = 12'(v);
    din_valid = 1'b1;
    got_bit   = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      observe();
    end
  endtask

  task automatic send_sym(input int v);
    for (int i = 0; i < 16; i++) sample(v);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_frame(input logic [15:0] sw, input logic neg, input int nbits);
    logic [95:0] fr;
    fr = {16'hAAAA, sw, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < nbits; i++) send_sym((fr[95-i] ^ neg) ? 1000 : -1000);
  endtask

  task automatic check_frame(input string tag, input logic exp_inv);
    logic [63:0] pay;
    logic [31:0] got;
    pay = 64'h0123_4567_89AB_CDEF;
    chk({tag, " frame_start count"}, fs_cnt, 1);
    chk({tag, " frame_start latency"}, fs_lat, 1);
    chk({tag, " sync at bit"}, fs_bits, 32);
    chk({tag, " inverted"}, fs_inv, exp_inv);
    chk({tag, " byte count"}, rx_bytes.size(), 8);
    for (int i = 0; i < 8; i++) begin
      got = (i < rx_bytes.size()) ? 32'(rx_bytes[i]) : 32'hDEAD;
      chk({tag, " byte"}, got, pay[63-8*i -: 8]);
    end
    chk({tag, " frame_end count"}, fe_cnt, 1);
    chk({tag, " frame_end byte"}, fe_byte, 8'hEF);
    chk({tag, " frame_end with byte_valid"}, fe_bv, 1'b1);
    chk({tag, " unlocked after"}, locked, 1'b0);
    chk({tag, " byte_out held"}, byte_out, 8'hEF);
  endtask

  initial begin
    int n_lock;
    int n_bits;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    gap       = 2;
    clear_log();
    @(negedge clk);
    chk("reset bit_valid", bit_valid, 1'b0);
    chk("reset bit_out", bit_out, 1'b0);
    chk("reset byte_out", byte_out, 8'h00);
    chk("reset byte_valid", byte_valid, 1'b0);
    chk("reset frame_start", frame_start, 1'b0);
    chk("reset frame_end", frame_end, 1'b0);
    chk("reset locked", locked, 1'b0);
    chk("reset inverted", inverted, 1'b0);

    // Square wave, 5-sample offset, one sample every 16 clk.
    do_reset();
    gap    = 16;
    n_lock = 0;
    for (int n = 0; n < 5 + 16 * 20; n++) begin
      sample((n < 5) ? -1000 : ((((n - 5) / 16) % 2 == 0) ? 1000 : -1000));
      if (got_bit && n >= 5 + 16 * 12) begin
        chk("square decision phase", n % 16, 13);
        chk("square bit", last_bit, (((n - 5) / 16) % 2 == 0) ? 1'b1 : 1'b0);
        n_lock++;
      end
    end
    chk("square decision rate", n_lock, 8);

    // Level, noise and threshold boundaries.
    gap = 2;
    do_reset();
    send_sym(1000);
    chk("level high", last_bit, 1'b1);
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 16; i++) sample(500 + int'($urandom_range(80)) - 40);
      chk("noise bit", last_bit, 1'b1);
    end
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 16; i++) sample(int'($urandom_range(120)) - 60);
      chk("hysteresis hold bit", last_bit, 1'b1);
    end
    send_sym(-64);
    chk("at -HYST holds", last_bit, 1'b1);
    send_sym(-65);
    chk("below -HYST", last_bit, 1'b0);
    send_sym(64);
    chk("at +HYST holds", last_bit, 1'b0);
    send_sym(65);
    chk("above +HYST", last_bit, 1'b1);
    send_sym(-2048);
    chk("full scale negative", last_bit, 1'b0);
    send_sym(2047);
    chk("full scale positive", last_bit, 1'b1);
    n_bits = 1 + 6 + 3 + 6;
    chk("one decision per symbol", bits_seen, n_bits);
    chk("no sync on levels", fs_cnt, 0);

    do_reset();
    send_frame(16'hD391, 1'b0, 96);
    repeat (2) send_sym(0);
    check_frame("normal", 1'b0);

    do_reset();
    send_frame(16'hD391, 1'b1, 96);
    repeat (2) send_sym(0);
    check_frame("negated", 1'b1);

    do_reset();
    send_frame(16'hD393, 1'b0, 96);
    repeat (2) send_sym(0);
    check_frame("one bit error", 1'b0);

    do_reset();
    send_frame(16'hD397, 1'b0, 32);
    repeat (20) send_sym(0);
    chk("two bit error frame_start", fs_cnt, 0);
    chk("two bit error never locked", lock_seen, 1'b0);
    chk("two bit error decisions", bits_seen, 52);

    // Reset in the middle of a frame.
    do_reset();
    send_frame(16'hD391, 1'b0, 56);
    chk("partial byte count", rx_bytes.size(), 3);
    chk("partial locked", locked, 1'b1);
    chk("partial last byte", byte_out, 8'h45);
    rst = 1'b1;
    #1;
    chk("mid reset locked", locked, 1'b0);
    chk("mid reset byte_out", byte_out, 8'h00);
    chk("mid reset bit_out", bit_out, 1'b0);
    chk("mid reset inverted", inverted, 1'b0);
    chk("mid reset strobes", {bit_valid, byte_valid, frame_start, frame_end}, 4'b0000);
    chk("mid reset no frame_end", fe_cnt, 0);
    do_reset();
    send_frame(16'hD391, 1'b0, 96);
    repeat (2) send_sym(0);
    check_frame("after reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
